// File: rtl/dm_access_ctrl.sv
// Memory-stage data-memory access controller: alignment check, ready-handshaked bus access,
// load extension. Optional bus timeout enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [2:0]  mem_mark,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        m_data_req,
    output logic [31:0] m_data_addr,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_wdata,
    input  logic        m_data_ready,
    input  logic [31:0] m_data_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  mark_q, mark_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_mem_op;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  byteen_new;
    logic [31:0] wdata_new;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic        timeout_hit;

    assign is_mem_op  = req_valid && (mem_mark != 3'd0) && (mem_mark != 3'd7);
    assign is_store   = (mem_mark <= 3'd3);
    assign misaligned = (((mem_mark == 3'd2) || (mem_mark == 3'd5)) && address[0]) ||
                        (((mem_mark == 3'd3) || (mem_mark == 3'd6)) && (address[1:0] != 2'b00));

    always_comb begin
        byteen_new = 4'b0000;
        wdata_new  = 32'd0;
        case (mem_mark)
            3'd1: begin
                byteen_new = 4'b0001 << address[1:0];
                wdata_new  = {4{wdata[7:0]}};
            end
            3'd2: begin
                byteen_new = 4'b0011 << {address[1], 1'b0};
                wdata_new  = {2{wdata[15:0]}};
            end
            3'd3: begin
                byteen_new = 4'b1111;
                wdata_new  = wdata;
            end
            default: ;
        endcase
    end

    // Lane selection uses the latched address so it matches the word on the bus.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = m_data_rdata[7:0];
            2'd1:    load_byte = m_data_rdata[15:8];
            2'd2:    load_byte = m_data_rdata[23:16];
            default: load_byte = m_data_rdata[31:24];
        endcase
        load_half = addr_q[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
        case (mark_q)
            3'd4:    load_ext = {{24{load_byte[7]}}, load_byte};
            3'd5:    load_ext = {{16{load_half[15]}}, load_half};
            3'd6:    load_ext = m_data_rdata;
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mark_d   = mark_q;
        addr_d   = addr_q;
        byteen_d = byteen_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        exc_adel = 1'b0;
        exc_ades = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem_op) begin
                    if (misaligned) begin
                        exc_adel = !is_store;
                        exc_ades = is_store;
                    end else begin
                        stall    = 1'b1;
                        state_d  = BUSY;
                        mark_d   = mem_mark;
                        addr_d   = address;
                        byteen_d = byteen_new;
                        wdata_d  = wdata_new;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (m_data_ready) begin
                    state_d = DONE;
                    rdata_d = load_ext;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mark_q   <= 3'd0;
            addr_q   <= 32'd0;
            byteen_q <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            mark_q   <= mark_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef DM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Error flag is only ever set on the BUSY->DONE edge taken by a timeout.
    always_comb begin
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        if (state_q == IDLE) begin
            cnt_d     = '0;
            bus_err_d = 1'b0;
        end else if (state_q == BUSY) begin
            bus_err_d = !m_data_ready && timeout_hit;
            if (!m_data_ready) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign exc_bus = (state_q == DONE) && bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign exc_bus     = 1'b0;
`endif

    assign m_data_req    = (state_q == BUSY);
    assign rdata_valid   = (state_q == DONE);
    assign rdata         = rdata_q;
    assign m_data_addr   = {addr_q[31:2], 2'b00};
    assign m_data_byteen = byteen_q;
    assign m_data_wdata  = wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: spec vector table, randomized accesses against an
// arithmetic reference model, timeout (when DM_TIMEOUT_EN is defined) and mid-access reset.
module tb_dm_access_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  mem_mark;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic        m_data_req;
    logic [31:0] m_data_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_wdata;
    logic        m_data_ready;
    logic [31:0] m_data_rdata;

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] model_rdata = 32'd0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .mem_mark(mem_mark),
        .address(address), .wdata(wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_bus(exc_bus), .m_data_req(m_data_req), .m_data_addr(m_data_addr),
        .m_data_byteen(m_data_byteen), .m_data_wdata(m_data_wdata),
        .m_data_ready(m_data_ready), .m_data_rdata(m_data_rdata)
    );

    typedef struct {
        logic [2:0]  mk;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rw;
        int          dly;
        logic [31:0] e_rd;
        logic [31:0] e_be;
        logic [31:0] e_wd;
        logic        e_adel;
        logic        e_ades;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] mk);
        case (mk)
            3'd1, 3'd4: return 1;
            3'd2, 3'd5: return 2;
            3'd3, 3'd6: return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input int sz, input logic [31:0] ad, input logic [31:0] rw);
        logic [31:0] lane;
        logic [31:0] v;
        lane = rw >> (8 * (ad % 4));
        if (sz == 1) begin
            v = lane & 32'hFF;
            if (v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2) begin
            v = lane & 32'hFFFF;
            if (v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rw;
        end
        return v;
    endfunction

    // dly: BUSY cycle index (1-based) in which ready arrives; 0 = never.
    task automatic access(input logic [2:0] mk, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] rw, input int dly, input logic [31:0] e_rd,
                          input logic [31:0] e_be, input logic [31:0] e_wd,
                          input logic e_adel, input logic e_ades);
        bit mem_op;
        bit mis;
        bit st;
        bit to_err;
        bit got_ready;
        mem_op    = (mk != 3'd0) && (mk != 3'd7);
        mis       = e_adel || e_ades;
        st        = (mk >= 3'd1) && (mk <= 3'd3);
        to_err    = 1'b0;
        got_ready = 1'b0;

        @(negedge clk);
        req_valid = 1'b1; mem_mark = mk; address = ad; wdata = wd; m_data_ready = 1'b0;
        #1;
        chk("idle_rvalid", rdata_valid, 1'b0);
        chk("idle_rdata_hold", rdata, model_rdata);
        chk("accept_stall", stall, mem_op && !mis);
        chk("accept_adel", exc_adel, e_adel);
        chk("accept_ades", exc_ades, e_ades);
        chk("accept_req", m_data_req, 1'b0);
        if (!mem_op || mis) begin
            $display("txn mk=%0d addr=%h no bus access adel=%0d ades=%0d", mk, ad, exc_adel, exc_ades);
            return;
        end

        @(negedge clk);
        req_valid = 1'b0; mem_mark = 3'($urandom); address = $urandom; wdata = $urandom;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) @(negedge clk);
            m_data_ready = (k == dly);
            m_data_rdata = (k == dly) ? rw : $urandom;
            #1;
            chk("busy_req", m_data_req, 1'b1);
            chk("busy_stall", stall, 1'b1);
            chk("busy_addr", m_data_addr, ad & 32'hFFFF_FFFC);
            chk("busy_byteen", m_data_byteen, e_be);
            if (st) chk("busy_wdata", m_data_wdata, e_wd);
            if (k == dly) begin
                got_ready = 1'b1;
                break;
            end
`ifdef DM_TIMEOUT_EN
            if (k == TO) begin
                to_err = 1'b1;
                break;
            end
`endif
        end
        if (!got_ready && !to_err) begin
            n_checks++;
            n_err++;
            $display("FAIL busy_bound: access mk=%0d addr=%h never completed", mk, ad);
            $display("Result: errors=%0d of %0d checks", n_err, n_checks);
            $finish;
        end

        // DONE cycle: drive a late ready and a misaligned request, both must be ignored.
        @(negedge clk);
        m_data_ready = 1'($urandom);
        req_valid = 1'b1; mem_mark = 3'd3; address = 32'h2;
        #1;
        if (got_ready) model_rdata = e_rd;
        chk("done_rvalid", rdata_valid, 1'b1);
        chk("done_stall", stall, 1'b0);
        chk("done_req", m_data_req, 1'b0);
        chk("done_bus", exc_bus, to_err);
        chk("done_ades", exc_ades, 1'b0);
        chk("done_rdata", rdata, model_rdata);
        m_data_ready = 1'b0;
        $display("txn mk=%0d addr=%h rdata=%h exc_bus=%0d", mk, ad, rdata, exc_bus);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; mem_mark = 3'd0; address = 32'd0; wdata = 32'd0;
        m_data_ready = 1'b0; m_data_rdata = 32'd0;

        //         mk    addr          wdata         rword         dly e_rdata       e_be  e_wdata       adel  ades
        tbl[0] = '{3'd6, 32'h0000_0100, 32'h0,        32'h8899_AABB, 2, 32'h8899_AABB, 32'h0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{3'd4, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 32'hFFFF_FF80, 32'h0, 32'h0,        1'b0, 1'b0};
        tbl[2] = '{3'd5, 32'h0000_0102, 32'h0,        32'h7FFF_1234, 3, 32'h0000_7FFF, 32'h0, 32'h0,        1'b0, 1'b0};
        tbl[3] = '{3'd5, 32'h0000_0100, 32'h0,        32'h7FFF_8001, 1, 32'hFFFF_8001, 32'h0, 32'h0,        1'b0, 1'b0};
        tbl[4] = '{3'd1, 32'h0000_0201, 32'h0000_00A5, 32'h1111_1111, 1, 32'h0,        32'h2, 32'hA5A5_A5A5, 1'b0, 1'b0};
        tbl[5] = '{3'd2, 32'h0000_0202, 32'h0000_1234, 32'h2222_2222, 2, 32'h0,        32'hC, 32'h1234_1234, 1'b0, 1'b0};
        tbl[6] = '{3'd3, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,         1, 32'h0,        32'h0, 32'h0,        1'b0, 1'b1};
        tbl[7] = '{3'd5, 32'h0000_0101, 32'h0,        32'h0,         1, 32'h0,        32'h0, 32'h0,        1'b1, 1'b0};
        tbl[8] = '{3'd3, 32'h0000_0300, 32'hDEAD_BEEF, 32'h3333_3333, 4, 32'h0,        32'hF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[9] = '{3'd7, 32'h0000_0400, 32'h0,        32'h0,         1, 32'h0,        32'h0, 32'h0,        1'b0, 1'b0};

        #12;
        chk("rst_stall", stall, 1'b0);
        chk("rst_rvalid", rdata_valid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_req", m_data_req, 1'b0);
        chk("rst_addr", m_data_addr, 32'd0);
        chk("rst_byteen", m_data_byteen, 32'd0);
        chk("rst_wdata", m_data_wdata, 32'd0);
        chk("rst_exc", {exc_adel, exc_ades, exc_bus}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++)
            access(tbl[i].mk, tbl[i].ad, tbl[i].wd, tbl[i].rw, tbl[i].dly,
                   tbl[i].e_rd, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_adel, tbl[i].e_ades);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  mk;
            logic [31:0] ad, wd, rw, e_be, e_wd, e_rd;
            int          sz;
            bit          st, mis;
            mk = 3'($urandom_range(0, 7));
            ad = $urandom; wd = $urandom; rw = $urandom;
            sz = size_of(mk);
            st = (mk >= 3'd1) && (mk <= 3'd3);
            mis = (sz > 1) && ((ad % sz) != 0);
            e_be = st ? (((32'd1 << sz) - 1) << (ad % 4)) : 32'd0;
            if (sz == 1)      e_wd = (wd & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
            else              e_wd = wd;
            e_rd = st ? 32'd0 : load_model(sz, ad, rw);
            access(mk, ad, wd, rw, $urandom_range(1, 5), e_rd, e_be, e_wd, mis && !st, mis && st);
        end

`ifdef DM_TIMEOUT_EN
        access(3'd6, 32'h500, 32'h0, 32'h1111_1111, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        access(3'd6, 32'h504, 32'h0, 32'hCAFE_F00D, TO, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 1'b0);
`else
        access(3'd6, 32'h504, 32'h0, 32'hCAFE_F00D, 40, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 1'b0);
`endif

        // Reset in the middle of a BUSY phase abandons the access.
        @(negedge clk);
        req_valid = 1'b1; mem_mark = 3'd1; address = 32'h403; wdata = 32'h5A; m_data_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_req", m_data_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", m_data_req, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_addr", m_data_addr, 32'd0);
        chk("mid_rst_byteen", m_data_byteen, 32'd0);
        chk("mid_rst_wdata", m_data_wdata, 32'd0);
        chk("mid_rst_rvalid", rdata_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        model_rdata = 32'd0;
        $display("txn reset during BUSY");
        access(3'd6, 32'h600, 32'h0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 32'h0, 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        req_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
